delay_chain_counter: RTL

// - Synthesisable, parametrised successor to the lab's delayed-assignment model.
// - Stage 0 is a free-running counter that increments every PERIOD clocks.
// - A load seeds stage 0, then a timed chain writes stage k = stage k-1 + 1 every HOP clocks.
// - Sits in the lab timing-demo datapath as a cycle-accurate source of staged, delayed values.

---
 rtl/delay_chain_counter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/delay_chain_counter.sv
// rtl/delay_chain_counter.sv - free-running stage-0 counter with a timed +1 propagation chain (option: DCC_SAT_EN)
//
// Stage 0 counts every PERIOD enabled clocks. A load seeds stage 0 and starts
// a chain that writes stage k = stage k-1 + 1 every HOP clocks, then pulses done.
// Define DCC_SAT_EN to make every +1 saturate at all-ones instead of wrapping.

module delay_chain_counter #(
  parameter int WIDTH   = 32,
  parameter int PERIOD  = 7,
  parameter int HOP     = 10,
  parameter int NSTAGES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       load,
  input  logic [WIDTH-1:0]           load_val,
  output logic                       busy,
  output logic                       done,
  output logic [NSTAGES-1:0]         stage_vld,
  output logic [NSTAGES*WIDTH-1:0]   stage_q
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;
  // One extra bit so the stage index can step past the last stage harmlessly.
  localparam int SW = $clog2(NSTAGES) + 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(PERIOD - 1);
  localparam logic [HW-1:0] HOP_MAX   = HW'(HOP - 1);
  localparam logic [SW-1:0] LAST_STG  = SW'(NSTAGES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PROP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_presc;
  logic [HW-1:0]      r_hop;
  logic [SW-1:0]      r_stg;
  logic [WIDTH-1:0]   r_stage [NSTAGES];
  logic [NSTAGES-1:0] r_vld;
  logic               r_done;

  logic w_tick;
  logic w_hop_end;
  logic w_accept;
  logic w_write;
  logic w_last;

  // Shared +1 used by the stage-0 tick and every stage write.
  function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] x);
`ifdef DCC_SAT_EN
    f_inc = (&x) ? x : x + 1'b1;
`else
    f_inc = x + 1'b1;
`endif
  endfunction

  assign w_tick    = en && (r_presc == PRESC_MAX);
  assign w_hop_end = (r_hop == HOP_MAX);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the load-accept and stage-write strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_write     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PROP;
        end
      end
      S_PROP: begin
        // load is ignored here; only the hop timer advances the chain.
        if (w_hop_end) begin
          w_write = 1'b1;
          if (r_stg == LAST_STG) begin
            w_last      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prescaler: a load restarts it so ticks are measured from the load edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_accept) begin
      r_presc <= '0;
    end else if (en) begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Hop timer and index of the next stage to be written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hop <= '0;
      r_stg <= '0;
    end else if (w_accept) begin
      r_hop <= '0;
      r_stg <= SW'(1);
    end else if (r_state == S_PROP) begin
      if (w_hop_end) begin
        r_hop <= '0;
        r_stg <= r_stg + 1'b1;
      end else begin
        r_hop <= r_hop + 1'b1;
      end
    end
  end

  // Stage registers: stage 0 loads or ticks, stage k copies stage k-1 + 1 on its hop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      // The seed wins over a coincident tick, so load_val is stored as-is.
      if (w_accept) begin
        r_stage[0] <= load_val;
      end else if (w_tick) begin
        r_stage[0] <= f_inc(r_stage[0]);
      end
      for (int k = 1; k < NSTAGES; k++) begin
        if (w_write && (r_stg == SW'(k))) begin
          r_stage[k] <= f_inc(r_stage[k-1]);
        end
      end
    end
  end

  // Valid bits: a load marks only stage 0; each stage write adds its own bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_accept) begin
      r_vld <= NSTAGES'(1);
    end else begin
      for (int k = 1; k < NSTAGES; k++) begin
        if (w_write && (r_stg == SW'(k))) begin
          r_vld[k] <= 1'b1;
        end
      end
    end
  end

  // done is a one-cycle pulse following the last stage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
    end
  end

  // Flatten the stage array onto the output bus.
  always_comb begin
    stage_q = '0;
    for (int k = 0; k < NSTAGES; k++) begin
      stage_q[k*WIDTH +: WIDTH] = r_stage[k];
    end
  end

  assign busy      = (r_state == S_PROP);
  assign done      = r_done;
  assign stage_vld = r_vld;

endmodule
